// File: rtl/cmsdk_apb4_eg_master_if.sv
// cmsdk_apb4_eg_master_if: APB4 bus bundle between the example initiator and a completer
interface cmsdk_apb4_eg_master_if #(
    parameter int ADDRWIDTH = 12
);
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [ADDRWIDTH-1:0] paddr;
    logic [31:0]          pwdata;
    logic [3:0]           pstrb;
    logic [2:0]           pprot;
    logic [31:0]          prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/cmsdk_apb4_eg_master.sv
// cmsdk_apb4_eg_master: turns a valid/ready command into one APB4 transfer and returns a valid/ready response
module cmsdk_apb4_eg_master #(
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 256
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDRWIDTH-1:0]   cmd_addr,
    input  logic [31:0]            cmd_wdata,
    input  logic [3:0]             cmd_strb,
    input  logic [2:0]             cmd_prot,
    cmsdk_apb4_eg_master_if.master apb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic                   rsp_timeout
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDRWIDTH-1:0] WORD_MASK = {{(ADDRWIDTH-2){1'b1}}, 2'b00};

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // Transfer sequencer: every bus and response output is a register updated here
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_ready   <= 1'b1;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            apb.pstrb   <= '0;
            apb.pprot   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        apb.paddr  <= cmd_addr & WORD_MASK;
                        apb.pwrite <= cmd_write;
                        apb.pprot  <= cmd_prot;
                        apb.pwdata <= cmd_write ? cmd_wdata : 32'h0;
                        apb.pstrb  <= cmd_write ? cmd_strb : 4'h0;
                        apb.psel   <= 1'b1;
                        cmd_ready  <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    apb.penable <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready) begin
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= apb.pwrite ? 32'h0 : apb.prdata;
                        rsp_err     <= apb.pslverr;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        cnt         <= cnt + 1'b1;
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= 32'h0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmsdk_apb4_eg_master.sv
// tb_cmsdk_apb4_eg_master: randomized self-checking bench acting as APB4 completer and command/response partner
module tb_cmsdk_apb4_eg_master;
    localparam int AW = 12;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    int            checks = 0;
    int            errors = 0;

    cmsdk_apb4_eg_master_if #(.ADDRWIDTH(AW)) bus ();

    cmsdk_apb4_eg_master #(.ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .apb(bus.master),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
    );

    always #5 pclk = ~pclk;

    task automatic scramble(input logic v);
        cmd_valid = v;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
    endtask

    // One complete command/response exchange checked against an arithmetic model of the protocol
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int waits,
                        input logic [31:0] rd, input logic se, input int hold, input logic busy_valid);
        logic [AW-1:0] e_addr;
        logic [31:0]   e_wdata;
        logic [31:0]   e_rdata;
        logic [3:0]    e_strb;
        logic          to;
        logic          e_err;
        logic          done;
        int            acc_exp;
        int            k;
        int            acc;
        int            ps;
        int            pe;
        e_addr  = AW'((int'(a) / 4) * 4);
        to      = (waits >= TO);
        acc_exp = to ? TO : waits + 1;
        e_wdata = w ? wd : 32'h0;
        e_strb  = w ? st : 4'h0;
        e_rdata = (to || w) ? 32'h0 : rd;
        e_err   = to ? 1'b1 : se;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
        k = 0; acc = 0; ps = 0; pe = 0; done = 1'b0;
        while (!done && k < 40) begin
            @(negedge pclk);
            k++;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                scramble(busy_valid);
                rsp_ready = 1'($urandom);
                checks++;
                if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_busy: got %b want 0 at cycle %0d", cmd_ready, k); end
                if (bus.psel) begin
                    ps++;
                    checks++;
                    if (bus.paddr !== e_addr) begin errors++; $display("FAIL paddr: got %h want %h", bus.paddr, e_addr); end
                    checks++;
                    if (bus.pwrite !== w) begin errors++; $display("FAIL pwrite: got %b want %b", bus.pwrite, w); end
                    checks++;
                    if (bus.pwdata !== e_wdata) begin errors++; $display("FAIL pwdata: got %h want %h", bus.pwdata, e_wdata); end
                    checks++;
                    if (bus.pstrb !== e_strb) begin errors++; $display("FAIL pstrb: got %h want %h", bus.pstrb, e_strb); end
                    checks++;
                    if (bus.pprot !== pr) begin errors++; $display("FAIL pprot: got %h want %h", bus.pprot, pr); end
                end
                if (bus.penable) pe++;
                if (bus.psel && bus.penable) begin
                    acc++;
                    bus.pready  = (acc == waits + 1);
                    bus.pslverr = bus.pready ? se : 1'($urandom);
                    bus.prdata  = bus.pready ? rd : $urandom;
                end else begin
                    bus.pready  = 1'b0;
                    bus.pslverr = 1'($urandom);
                    bus.prdata  = $urandom;
                end
            end
        end
        bus.pready = 1'b0;
        checks++;
        if (!done) begin
            errors++; $display("FAIL rsp_timeout_wait: no rsp_valid within %0d cycles", k);
            scramble(1'b0);
            return;
        end
        checks++;
        if (k !== acc_exp + 2) begin errors++; $display("FAIL rsp_latency: got %0d want %0d", k, acc_exp + 2); end
        checks++;
        if (ps !== acc_exp + 1) begin errors++; $display("FAIL psel_cycles: got %0d want %0d", ps, acc_exp + 1); end
        checks++;
        if (pe !== acc_exp) begin errors++; $display("FAIL penable_cycles: got %0d want %0d", pe, acc_exp); end
        checks++;
        if (rsp_rdata !== e_rdata) begin errors++; $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, e_rdata); end
        checks++;
        if (rsp_err !== e_err) begin errors++; $display("FAIL rsp_err: got %b want %b", rsp_err, e_err); end
        checks++;
        if (rsp_timeout !== to) begin errors++; $display("FAIL rsp_timeout: got %b want %b", rsp_timeout, to); end
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge pclk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e_rdata || rsp_err !== e_err || rsp_timeout !== to || cmd_ready !== 1'b0)
                begin errors++; $display("FAIL rsp_hold: got v%b d%h e%b t%b r%b want v1 d%h e%b t%b r0", rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, e_rdata, e_err, to); end
            scramble(busy_valid);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        scramble(1'b0);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || bus.psel !== 1'b0)
            begin errors++; $display("FAIL rsp_done: got v%b r%b s%b want v0 r1 s0", rsp_valid, cmd_ready, bus.psel); end
    endtask

    task automatic test_reset;
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        checks++;
        if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.psel, bus.penable, bus.pwrite}); end
        checks++;
        if ({bus.paddr, bus.pwdata, bus.pstrb, bus.pprot} !== '0) begin errors++; $display("FAIL reset_bus: got %h %h %h %h want 0", bus.paddr, bus.pwdata, bus.pstrb, bus.pprot); end
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin errors++; $display("FAIL reset_rsp: got %b %h %b %b want 0", rsp_valid, rsp_rdata, rsp_err, rsp_timeout); end
        preset = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_write_basic;
        xfer(1'b1, 12'h000, 32'hA5A5_1234, 4'hF, 3'h0, 0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_read_wait;
        xfer(1'b0, 12'hFE3, 32'hDEAD_BEEF, 4'hF, 3'h2, 2, 32'h19, 1'b0, 0, 1'b0);
    endtask

    task automatic test_slverr;
        xfer(1'b1, 12'h104, 32'h1111_2222, 4'hF, 3'h1, 1, 32'h0, 1'b1, 0, 1'b0);
        xfer(1'b1, 12'h108, 32'h3333_4444, 4'h5, 3'h0, 0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_timeout;
        xfer(1'b0, 12'h200, 32'h0, 4'h0, 3'h0, 100, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
        xfer(1'b0, 12'h204, 32'h0, 4'h0, 3'h0, 0, 32'h1234_5678, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        xfer(1'b0, 12'h300, 32'h0, 4'h0, 3'h4, 0, 32'h8765_4321, 1'b0, 5, 1'b1);
        xfer(1'b1, 12'h304, 32'h0BAD_F00D, 4'h3, 3'h7, 0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++)
            xfer(1'($urandom), AW'($urandom), $urandom, 4'($urandom), 3'($urandom),
                 $urandom_range(0, 5), $urandom, 1'($urandom), $urandom_range(0, 2), 1'($urandom));
    endtask

    task automatic test_reset_mid;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h400; cmd_wdata = 32'h0; cmd_strb = 4'h0; cmd_prot = 3'h0;
        bus.pready = 1'b0;
        @(negedge pclk);
        scramble(1'b0);
        @(negedge pclk);
        checks++;
        if (bus.penable !== 1'b1) begin errors++; $display("FAIL mid_access: got penable %b want 1", bus.penable); end
        preset = 1'b1;
        @(negedge pclk);
        checks++;
        if ({bus.psel, bus.penable, rsp_valid, cmd_ready} !== 4'b0001)
            begin errors++; $display("FAIL mid_reset: got %b want 0001", {bus.psel, bus.penable, rsp_valid, cmd_ready}); end
        preset = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            checks++;
            if ({bus.psel, rsp_valid, cmd_ready} !== 3'b001)
                begin errors++; $display("FAIL mid_after: got %b want 001", {bus.psel, rsp_valid, cmd_ready}); end
        end
    endtask

    initial begin
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
        test_reset;
        test_write_basic;
        test_read_wait;
        test_slverr;
        test_timeout;
        test_back_to_back;
        test_random;
        test_reset_mid;
        xfer(1'b0, 12'h010, 32'h0, 4'h0, 3'h0, 1, 32'h5555_AAAA, 1'b0, 0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
